// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing constants and receiver state type
package uart_pkg;

    localparam int CLK_FREQ     = 50000000;
    localparam int BAUD         = 115200;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - two-flop synchronizer with parameterised reset value
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling from the detected start edge
module uart_rx #(
    parameter int CLK_FREQ = uart_pkg::CLK_FREQ,
    parameter int BAUD     = uart_pkg::BAUD
) (
    input  logic       clk_slow,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    import uart_pkg::*;

    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int HALF  = (CPB - 1) / 2;
    localparam int CNT_W = $clog2(CPB);

    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CPB - 1);

    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_s;

    rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk_slow),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign rx_busy = (state != RX_IDLE);

    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= RX_START;
                end
                // Re-check the line half a bit in; a high here was a glitch.
                RX_START: begin
                    if (cnt == HALF_C) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == LAST_C) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == LAST_C) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            state    <= RX_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // A held-low line (break) must not be mistaken for a new start bit.
                RX_WAIT_HIGH: begin
                    cnt <= '0;
                    if (rx_s) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level expectation model
module tb_uart_rx;

    localparam int CPB    = 50000000 / 115200;
    localparam int HALF_B = (CPB - 1) / 2;
    // Two synchronizer edges plus the IDLE detection edge, then the stop-sample delay.
    localparam int OFFSET = 3 + HALF_B + 9 * CPB + 1;

    logic       clk_slow;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx #(.CLK_FREQ(50000000), .BAUD(115200)) dut (
        .clk_slow     (clk_slow),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial begin
        clk_slow = 1'b0;
        forever #5 clk_slow = ~clk_slow;
    end

    int cyc = 0;
    always @(posedge clk_slow) cyc <= cyc + 1;

    logic [7:0] exp_byte [0:15];
    bit         exp_err  [0:15];
    bit         exp_pin  [0:15];
    int         exp_cyc  [0:15];
    int         exp_fall [0:15];
    int         n_sent = 0;
    bit         expect_idle = 1'b0;
    bit         done = 1'b0;

    int         n_seen = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_data = 8'h00;
    bit         prev_pulse = 1'b0;
    int         d;

    always @(negedge clk_slow) begin
        if (rst) begin
            checks++;
            if ({rx_data, rx_valid, rx_frame_err, rx_busy} !== 11'd0) begin
                errors++;
                $display("FAIL reset_outputs got data=%h valid=%b err=%b busy=%b want all zero",
                         rx_data, rx_valid, rx_frame_err, rx_busy);
            end
            model_data = 8'h00;
            prev_pulse = 1'b0;
        end else begin
            if (rx_valid || rx_frame_err) begin
                checks++;
                if (rx_valid && rx_frame_err) begin
                    errors++;
                    $display("FAIL pulse_exclusive got valid=1 err=1 at cyc %0d want at most one", cyc);
                end
                checks++;
                if (prev_pulse) begin
                    errors++;
                    $display("FAIL pulse_width got pulse on two consecutive cycles at cyc %0d want one", cyc);
                end
                if (n_seen >= n_sent) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse got valid=%b err=%b at cyc %0d want none",
                             rx_valid, rx_frame_err, cyc);
                end else begin
                    checks++;
                    if (rx_frame_err != exp_err[n_seen]) begin
                        errors++;
                        $display("FAIL pulse_kind frame %0d got err=%b want err=%b",
                                 n_seen, rx_frame_err, exp_err[n_seen]);
                    end
                    d = cyc - exp_cyc[n_seen];
                    checks++;
                    if (d > 1 || d < -1) begin
                        errors++;
                        $display("FAIL pulse_time frame %0d got cyc %0d want %0d +/-1",
                                 n_seen, cyc, exp_cyc[n_seen]);
                    end
                    if (exp_pin[n_seen]) begin
                        checks++;
                        if ((cyc - exp_fall[n_seen]) < 4125 || (cyc - exp_fall[n_seen]) > 4127) begin
                            errors++;
                            $display("FAIL pin_latency got %0d want 4126 +/-1", cyc - exp_fall[n_seen]);
                        end
                        checks++;
                        if (rx_data !== 8'hA5) begin
                            errors++;
                            $display("FAIL pin_data got %h want a5", rx_data);
                        end
                    end
                    checks++;
                    if (rx_busy !== rx_frame_err) begin
                        errors++;
                        $display("FAIL busy_after_stop got %b want %b", rx_busy, rx_frame_err);
                    end
                    if (rx_valid && !exp_err[n_seen]) model_data = exp_byte[n_seen];
                    n_seen++;
                end
            end else if (n_seen < n_sent && cyc > exp_cyc[n_seen] + 1) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse frame %0d got none by cyc %0d want at %0d",
                         n_seen, cyc, exp_cyc[n_seen]);
                n_seen++;
            end
            checks++;
            if (rx_data !== model_data) begin
                errors++;
                $display("FAIL rx_data got %h want %h at cyc %0d", rx_data, model_data, cyc);
            end
            if (expect_idle) begin
                checks++;
                if (rx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_busy got %b want 0 at cyc %0d", rx_busy, cyc);
                end
            end
            prev_pulse = rx_valid || rx_frame_err;
        end
        if (done) begin
            checks++;
            if (n_seen != n_sent) begin
                errors++;
                $display("FAIL frame_count got %0d want %0d", n_seen, n_sent);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_slow);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        wait_cycles(300);
        expect_idle = 1'b1;
        wait_cycles(n - 300);
        expect_idle = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_v,
                              input int stop_len, input bit pin);
        rx = 1'b0;
        exp_byte[n_sent] = b;
        exp_err[n_sent]  = !stop_v;
        exp_pin[n_sent]  = pin;
        exp_fall[n_sent] = cyc;
        exp_cyc[n_sent]  = cyc + OFFSET;
        n_sent++;
        wait_cycles(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(per);
        end
        rx = stop_v;
        wait_cycles(stop_len);
        rx = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(5);
        rst = 1'b0;
        idle(500);

        send_frame(8'hA5, CPB, 1'b1, CPB, 1'b1);
        idle(1000);

        send_frame(8'h00, CPB, 1'b1, CPB, 1'b0);
        send_frame(8'hFF, CPB, 1'b1, CPB, 1'b0);
        idle(1000);

        rx = 1'b0;
        wait_cycles(100);
        idle(1000);

        send_frame(8'h3C, CPB, 1'b0, 10000, 1'b0);
        idle(1000);
        send_frame(8'h5A, CPB, 1'b1, CPB, 1'b0);
        idle(1000);

        // Frame 0x81 abandoned by reset halfway through data bit 3.
        rx = 1'b0;
        wait_cycles(CPB);
        rx = 1'b1;
        wait_cycles(CPB);
        rx = 1'b0;
        wait_cycles(CPB);
        wait_cycles(CPB);
        wait_cycles(CPB / 2);
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(20);
        rst = 1'b0;
        idle(1000);
        send_frame(8'h42, CPB, 1'b1, CPB, 1'b0);
        idle(1000);

        send_frame(8'h96, 425, 1'b1, 425, 1'b0);
        idle(1000);
        send_frame(8'h96, 443, 1'b1, 443, 1'b0);
        idle(1000);

        done = 1'b1;
        wait_cycles(5);
        $display("FAIL end_of_test summary not reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz SHALL be provided.
REQ-002 Parameter BAUD, default 115200, serial bit rate SHALL be provided.
REQ-003 Port clk_slow  input  1  single system clock; all flops SHALL be on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 Port rx_data  output  8  last correctly framed byte.
REQ-007 Port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-008 Port rx_frame_err  output  1  one-cycle pulse on stop bit sampled low.
REQ-009 Port rx_busy  output  1  high in every state except IDLE.

Function
REQ-010 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD with integer truncation (434 at defaults); HALF_BIT SHALL equal (CLKS_PER_BIT-1)/2 (216).
REQ-011 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide (9 at defaults), count 0..CLKS_PER_BIT-1 and wrap to 0.
REQ-012 rx SHALL pass through a 2-flop synchronizer reset to 1; all decisions SHALL use the synchronized value rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: counter held at 0; rx_s==0 -> START.
REQ-015 START: counter reaching HALF_BIT -> sample rx_s; 0 -> DATA with counter and bit index cleared; 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: each time counter reaches CLKS_PER_BIT-1, rx_s SHALL be shifted into the shift register at bit index (LSB first) and index incremented; after index 7 -> STOP.
REQ-017 STOP: counter reaching CLKS_PER_BIT-1 -> sample rx_s; 1 -> rx_data <= shift register, rx_valid=1 for exactly the next cycle, -> IDLE; 0 -> rx_frame_err=1 for exactly the next cycle, rx_data unchanged, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rx_s==1, then -> IDLE; no new frame SHALL start while the line is held low (break).
REQ-019 Stop-bit sample SHALL occur HALF_BIT+9*CLKS_PER_BIT+1 cycles (4123 at defaults) after IDLE first sees rx_s==0, within +/-1 cycle; rx_valid SHALL follow it by one cycle.
REQ-020 rx_valid and rx_frame_err SHALL never be high in the same cycle, nor high for two consecutive cycles.
REQ-021 A new start bit arriving immediately after a valid stop sample (back-to-back frames, no idle gap beyond stop half-bit) SHALL be received without loss.
REQ-022 Receiver SHALL tolerate transmitter baud error of +/-2%.

Reset
REQ-023 Asserting rst SHALL immediately force: state IDLE, counter 0, bit index 0, shift register 0x00, rx_data 0x00, rx_valid 0, rx_frame_err 0, rx_busy 0, synchronizer flops 1.
REQ-024 rst asserted mid-frame SHALL abandon the frame with no output pulse; reception SHALL resume on the next falling edge after release.

Structure
REQ-025 Package uart_pkg SHALL hold CLK_FREQ, BAUD, CLKS_PER_BIT, HALF_BIT and the rx state enum typedef, shared with the transmit side.
REQ-026 Sub-module rx_sync (2-flop synchronizer, reset value parameterised) SHALL be instantiated once; all other logic SHALL be in uart_rx.

Verification
REQ-027 Frame 0xA5 at 115200 -> rx_data=0xA5, single rx_valid pulse at REQ-019 timing, rx_frame_err never high.
REQ-028 Back-to-back frames 0x00 then 0xFF, no idle gap -> two rx_valid pulses, rx_data 0x00 then 0xFF.
REQ-029 rx low for 100 cycles then high -> returns to IDLE, no rx_valid, no rx_frame_err, rx_data unchanged.
REQ-030 Frame 0x3C with stop bit low, line held low 10000 cycles, then 0x5A -> one rx_frame_err pulse, rx_data stays previous value until 0x5A received after line goes high.
REQ-031 rst pulse during data bit 3 of frame 0x81, then frame 0x42 -> all outputs 0 during reset, only 0x42 reported.
REQ-032 Frames 0x96 sent at BAUD*1.02 and BAUD*0.98 -> both received as 0x96 with no frame error.
